serial_adder: RTL and testbench

- Bit-serial counterpart of the combinational full adder: one full-adder cell plus a carry flip-flop computes an N-bit sum LSB-first over N clock cycles.
- Takes parallel operands through a start/busy/done handshake and returns a parallel registered result.
- Sits beside the combinational adders as the area-minimal sequential implementation, and is checked against the same golden expression {cout,sum} = a + b + cin.

---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop adds two WIDTH-bit
// operands LSB-first over WIDTH cycles behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] sr_next;

  // Handshake: start is sampled only in IDLE and never queued; busy covers
  // SHIFT and DONE; done is a one-cycle pulse while sum/cout hold the new result.
  always_comb begin
    s      = sa[0] ^ sb[0] ^ c;
    c_next = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  end

  // Each sum bit enters at the MSB, so after WIDTH shifts sr holds the sum in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sr_next = s;
    end else begin : g_wn
      assign sr_next = {s, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          c   <= c_next;
          sr  <= sr_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sr_next;
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake, timing and
// reset scenarios, and a 3-bit instance swept over every operand combination.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       cin3 = 1'b0;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_add8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) u_add3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
    end
    checks++;
    if ({busy3, done3, sum3, cout3} !== 6'd0) begin
      errors++;
      $display("FAIL reset_w3: busy=%b done=%b sum=%h cout=%b, required all 0", busy3, done3, sum3, cout3);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // One 8-bit operation with a single-cycle start pulse; checks latency, busy
  // length, the result, and that the previous result holds until completion.
  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] exp_s, input logic exp_c,
                     input logic [7:0] hold_s, input logic hold_c);
    int  lat;
    int  busy_cnt;
    bit  got;
    bit  hold_ok;
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~ci;
    lat = 0; busy_cnt = 0; got = 1'b0; hold_ok = 1'b1;
    while (!got && lat < 20) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        got = 1'b1;
      end else begin
        if (sum8 !== hold_s || cout8 !== hold_c) hold_ok = 1'b0;
        step();
        lat++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done at 8", name, lat);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, required 8", name, lat);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s_hold: sum/cout changed before done, required %h/%b held", name, hold_s, hold_c);
    end
    checks++;
    if (sum8 !== exp_s || cout8 !== exp_c) begin
      errors++;
      $display("FAIL %s_result: sum=%h cout=%b, required sum=%h cout=%b", name, sum8, cout8, exp_s, exp_c);
    end
    step();
    if (busy8) busy_cnt++;
    checks++;
    if (busy_cnt !== 9) begin
      errors++;
      $display("FAIL %s_busy_len: busy high %0d cycles, required 9", name, busy_cnt);
    end
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b, required 0/0", name, done8, busy8);
    end
  endtask

  task automatic test_basic();
    op8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_hold();
    op8("a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    op8("12_34_hold", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_start_ignored();
    int  lat;
    int  ndone;
    bit  extra;
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0; ndone = 0;
    while (ndone == 0 && lat < 20) begin
      step();
      lat++;
      if (lat == 2 || lat == 5) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = 8'h0C; b8 = 8'h0C; cin8 = 1'b0;
      end
      if (done8) ndone++;
    end
    start8 = 1'b0;
    checks++;
    if (ndone !== 1 || lat !== 8) begin
      errors++;
      $display("FAIL restart_timing: done count=%0d at cycle %0d, required 1 at 8", ndone, lat);
    end
    checks++;
    if (sum8 !== 8'h78 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: sum=%h cout=%b, required 78/0", sum8, cout8);
    end
    extra = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i > 0 && (busy8 || done8)) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL restart_no_extra_op: busy/done seen after completion, required idle");
    end
  endtask

  task automatic test_back_to_back();
    int last_done;
    int npulse;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    last_done = -1; npulse = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      step();
      if (done8) begin
        npulse++;
        checks++;
        if (sum8 !== 8'h02 || cout8 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result: sum=%h cout=%b, required 02/0", sum8, cout8);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 10) begin
            errors++;
            $display("FAIL b2b_cadence: pulse gap %0d cycles, required 10", cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
    start8 = 1'b0;
    checks++;
    if (npulse !== 4) begin
      errors++;
      $display("FAIL b2b_pulse_count: %0d done pulses in 45 cycles, required 4", npulse);
    end
    for (int i = 0; i < 12 && busy8; i++) step();
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    a8 = 8'h0F; b8 = 8'hF0; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL midop_no_done: activity after aborted op, required none");
    end
    op8("after_reset", 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_exhaustive_w3();
    int         err0;
    int         ndone;
    int         dlat;
    logic [3:0] got;
    logic [3:0] exp;
    logic [6:0] v;
    err0 = errors;
    for (int n = 0; n < 128; n++) begin
      v = 7'(n);
      a3 = v[6:4]; b3 = v[3:1]; cin3 = v[0];
      exp = 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      a3 = ~v[6:4]; b3 = ~v[3:1]; cin3 = ~v[0];
      ndone = 0; dlat = -1; got = 'x;
      for (int lat = 1; lat <= 8; lat++) begin
        step();
        if (done3) begin
          ndone++;
          dlat = lat;
          got = {cout3, sum3};
        end
        if (!busy3) break;
      end
      checks++;
      if (ndone !== 1 || dlat !== 3) begin
        errors++;
        $display("FAIL w3_done t=%0t a=%0d b=%0d cin=%0d: %0d pulses at cycle %0d, required 1 at 3",
                 $time, v[6:4], v[3:1], v[0], ndone, dlat);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL w3_sum t=%0t a=%0d b=%0d cin=%0d: {cout,sum}=%0d, required %0d",
                 $time, v[6:4], v[3:1], v[0], got, exp);
      end
    end
    if (errors == err0) $display("PASS!!");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive_w3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
